bsg_manycore_mem_responder: RTL



---
 rtl/bsg_manycore_mem_responder_pkg.sv | 30 +++
 rtl/bsg_manycore_mem_responder_if.sv | 35 +++
 rtl/bsg_manycore_mem_responder_load_fmt.sv | 27 ++
 rtl/bsg_manycore_mem_responder.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bsg_manycore_mem_responder_pkg.sv
// bsg_manycore_mem_resp_pkg: shared types for the manycore memory responder.
// Revision: 1.0
`default_nettype none

package bsg_manycore_mem_resp_pkg;

  localparam int mem_resp_load_info_width_gp = 5;

  typedef struct packed {
    logic       is_unsigned_op;
    logic       is_byte_op;
    logic       is_hex_op;
    logic [1:0] part_sel;
  } mem_resp_load_info_s;

  typedef enum logic [1:0] {
    e_amo_swap = 2'd0,
    e_amo_add  = 2'd1,
    e_amo_or   = 2'd2,
    e_amo_and  = 2'd3
  } mem_resp_amo_op_e;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    AMO_RMW = 1'b1
  } mem_resp_state_e;

endpackage

`default_nettype wire

// File: rtl/bsg_manycore_mem_responder_if.sv
// bsg_manycore_mem_responder_if: endpoint rx request / response bundle.
// Revision: 1.0
`default_nettype none

interface bsg_manycore_mem_responder_if #(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 28
);
  logic                    in_v_i;
  logic                    in_we_i;
  logic [addr_width_p-1:0] in_addr_i;
  logic [data_width_p-1:0] in_data_i;
  logic [data_width_p/8-1:0] in_mask_i;
  logic [bsg_manycore_mem_resp_pkg::mem_resp_load_info_width_gp-1:0] in_load_info_i;
  logic                    in_amo_v_i;
  logic [1:0]              in_amo_op_i;
  logic                    in_yumi_o;
  logic                    returning_v_o;
  logic [data_width_p-1:0] returning_data_o;
  logic                    err_o;

  modport master (
    output in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i, in_load_info_i,
           in_amo_v_i, in_amo_op_i,
    input  in_yumi_o, returning_v_o, returning_data_o, err_o
  );

  modport slave (
    input  in_v_i, in_we_i, in_addr_i, in_data_i, in_mask_i, in_load_info_i,
           in_amo_v_i, in_amo_op_i,
    output in_yumi_o, returning_v_o, returning_data_o, err_o
  );
endinterface

`default_nettype wire

// File: rtl/bsg_manycore_mem_responder_load_fmt.sv
// bsg_manycore_mem_responder_load_fmt: sub-word extract and sign/zero extend.
// Revision: 1.0
`default_nettype none

module bsg_manycore_mem_responder_load_fmt
  import bsg_manycore_mem_resp_pkg::*;
(
  input  logic [31:0]         raw_i,
  input  mem_resp_load_info_s info_i,
  output logic [31:0]         data_o
);
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = raw_i[8*info_i.part_sel +: 8];
    w_half = info_i.part_sel[1] ? raw_i[31:16] : raw_i[15:0];
    data_o = raw_i;
    if (info_i.is_byte_op) begin
      data_o = {{24{w_byte[7] & ~info_i.is_unsigned_op}}, w_byte};
    end else if (info_i.is_hex_op) begin
      data_o = {{16{w_half[15] & ~info_i.is_unsigned_op}}, w_half};
    end
  end
endmodule

`default_nettype wire

// File: rtl/bsg_manycore_mem_responder.sv
// bsg_manycore_mem_responder: SRAM target for endpoint rx requests, one response each.
// Optional AMO read-modify-write enabled by BSG_MANYCORE_MEM_RESPONDER_AMO_EN. Revision: 1.0
`default_nettype none

module bsg_manycore_mem_responder
  import bsg_manycore_mem_resp_pkg::*;
#(
  parameter int data_width_p = 32,
  parameter int addr_width_p = 28,
  parameter int mem_els_p    = 1024
)
(
  input  logic clk_i,
  input  logic reset_n_i,
  bsg_manycore_mem_responder_if.slave bus
);
  localparam int mem_addr_width_lp = (mem_els_p > 1) ? $clog2(mem_els_p) : 1;
  localparam int mask_width_lp     = data_width_p / 8;

  logic [data_width_p-1:0] mem [mem_els_p];

  mem_resp_state_e         state_q, state_d;
  logic                    v_q, v_d, err_q, err_d, oor_q, oor_d;
  logic                    load_q, load_d, amo_q, amo_d;
  logic [data_width_p-1:0] rdata_q, rdata_d, amo_data_q, amo_data_d;
  mem_resp_load_info_s     info_q, info_d;
  mem_resp_amo_op_e        amo_op_q, amo_op_d;
  logic [mem_addr_width_lp-1:0] idx_q, idx_d;

  logic                         w_yumi, w_in_range, w_amo_accept, w_we;
  logic [mem_addr_width_lp-1:0] w_idx, w_widx;
  logic [data_width_p-1:0]      w_wdata, w_amo_result, w_fmt, w_resp;
  logic [mask_width_lp-1:0]     w_wmask;

  assign w_yumi     = bus.in_v_i & (state_q == IDLE) & reset_n_i;
  assign w_in_range = bus.in_addr_i < addr_width_p'(mem_els_p);
  assign w_idx      = bus.in_addr_i[mem_addr_width_lp-1:0];

`ifdef BSG_MANYCORE_MEM_RESPONDER_AMO_EN
  assign w_amo_accept = w_yumi & bus.in_amo_v_i;
`else
  logic unused_amo_v;
  assign unused_amo_v = bus.in_amo_v_i;
  assign w_amo_accept = 1'b0;
`endif

  always_comb begin
    state_d    = w_amo_accept ? AMO_RMW : IDLE;
    v_d        = w_yumi;
    err_d      = err_q | (w_yumi & ~w_in_range);
    rdata_d    = rdata_q;
    oor_d      = oor_q;
    load_d     = load_q;
    amo_d      = amo_q;
    info_d     = info_q;
    amo_op_d   = amo_op_q;
    amo_data_d = amo_data_q;
    idx_d      = idx_q;
    if (w_yumi) begin
      rdata_d    = mem[w_idx];
      oor_d      = ~w_in_range;
      load_d     = ~bus.in_we_i & ~w_amo_accept;
      amo_d      = w_amo_accept;
      info_d     = mem_resp_load_info_s'(bus.in_load_info_i);
      amo_op_d   = mem_resp_amo_op_e'(bus.in_amo_op_i);
      amo_data_d = bus.in_data_i;
      idx_d      = w_idx;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= IDLE;
      v_q        <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      oor_q      <= 1'b0;
      load_q     <= 1'b0;
      amo_q      <= 1'b0;
      info_q     <= '0;
      amo_op_q   <= e_amo_swap;
      amo_data_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      v_q        <= v_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      oor_q      <= oor_d;
      load_q     <= load_d;
      amo_q      <= amo_d;
      info_q     <= info_d;
      amo_op_q   <= amo_op_d;
      amo_data_q <= amo_data_d;
      idx_q      <= idx_d;
    end
  end

  // The RMW cycle owns the write port; the old word is the registered read data.
  always_comb begin
    case (amo_op_q)
      e_amo_add: w_amo_result = rdata_q + amo_data_q;
      e_amo_or:  w_amo_result = rdata_q | amo_data_q;
      e_amo_and: w_amo_result = rdata_q & amo_data_q;
      default:   w_amo_result = amo_data_q;
    endcase
    w_widx  = w_idx;
    w_wdata = bus.in_data_i;
    w_wmask = bus.in_mask_i;
    w_we    = w_yumi & bus.in_we_i & ~w_amo_accept & w_in_range;
    if (state_q == AMO_RMW) begin
      w_we    = ~oor_q;
      w_widx  = idx_q;
      w_wdata = w_amo_result;
      w_wmask = '1;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < mask_width_lp; b++) begin
      if (w_we && w_wmask[b]) begin
        mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  bsg_manycore_mem_responder_load_fmt u_load_fmt (
    .raw_i  (rdata_q),
    .info_i (info_q),
    .data_o (w_fmt)
  );

  always_comb begin
    w_resp = '0;
    if (v_q && !oor_q) begin
      if (amo_q)       w_resp = rdata_q;
      else if (load_q) w_resp = w_fmt;
    end
  end

  assign bus.in_yumi_o        = w_yumi;
  assign bus.returning_v_o    = v_q;
  assign bus.returning_data_o = w_resp;
  assign bus.err_o            = err_q;
endmodule

`default_nettype wire
